sid_i2s_tx: RTL and testbench

//  I2S transmitter that consumes the SID mixer's signed 16-bit sample stream and

---
 rtl/sid_i2s_tx.sv | 102 ++++++++++
 tb/tb_sid_i2s_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_i2s_tx.sv
// sid_i2s_tx: mono I2S transmitter for the SID mixer sample stream.
// A one-deep hold register is snapshotted once per frame; the newest sample wins.
module sid_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_sample_valid,
    input  logic [15:0] i_sample,
    output logic        o_bclk,
    output logic        o_lrclk,
    output logic        o_sdata,
    output logic        o_frame_start,
    output logic [7:0]  o_drop
);

    localparam logic [7:0] DIV_TC = 8'(BCLK_DIV - 1);

    logic [7:0]  r_div_cnt;
    logic        r_bclk;
    logic [4:0]  r_bit_cnt;
    logic        r_lrclk;
    logic        r_sdata;
    logic        r_frame_start;
    logic [7:0]  r_drop;
    logic [15:0] r_hold;
    logic [15:0] r_frame;
    logic        r_hold_full;

    logic        w_tc;
    logic        w_fall;
    logic        w_snap;
    logic [4:0]  w_bit_n;
    logic        w_ws_n;
    logic [3:0]  w_idx;

    assign w_tc    = (r_div_cnt == DIV_TC);
    assign w_fall  = w_tc & r_bclk;
    assign w_bit_n = r_bit_cnt + 5'd1;
    assign w_snap  = w_fall & (w_bit_n == 5'd0);
    // WS leads the slot MSB by one bit: high for bit_n 15..30
    assign w_ws_n  = (w_bit_n >= 5'd15) && (w_bit_n != 5'd31);
    assign w_idx   = 4'd15 - w_bit_n[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= 8'd0;
            r_bclk    <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= 8'd0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt     <= 5'd31;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame       <= 16'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_snap;
            if (w_fall) begin
                r_bit_cnt <= w_bit_n;
                r_lrclk   <= w_ws_n;
                if (w_snap) begin
                    r_frame <= r_hold;
                    r_sdata <= r_hold[15];
                end else begin
                    r_sdata <= r_frame[w_idx];
                end
            end
        end
    end

    // A sample landing on the snapshot cycle refills hold without a drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= 16'd0;
            r_hold_full <= 1'b0;
            r_drop      <= 8'd0;
        end else if (i_sample_valid) begin
            r_hold      <= i_sample;
            r_hold_full <= 1'b1;
            if (r_hold_full && !w_snap && (r_drop != 8'hff)) begin
                r_drop <= r_drop + 8'd1;
            end
        end else if (w_snap) begin
            r_hold_full <= 1'b0;
        end
    end

    assign o_bclk        = r_bclk;
    assign o_lrclk       = r_lrclk;
    assign o_sdata       = r_sdata;
    assign o_frame_start = r_frame_start;
    assign o_drop        = r_drop;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb_sid_i2s_tx: randomized and directed bench for sid_i2s_tx.
// Expected pins come from frame/bit arithmetic on the edge count since reset.
module tb_sid_i2s_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_n1, vld, vld1;
    logic [15:0] smp, smp1;
    logic        b4, lr4, sd4, fs4, b1, lr1, sd1, fs1;
    logic [7:0]  dr4, dr1;

    sid_i2s_tx #(.BCLK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_sample_valid(vld), .i_sample(smp),
        .o_bclk(b4), .o_lrclk(lr4), .o_sdata(sd4),
        .o_frame_start(fs4), .o_drop(dr4)
    );

    sid_i2s_tx #(.BCLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .i_sample_valid(vld1), .i_sample(smp1),
        .o_bclk(b1), .o_lrclk(lr1), .o_sdata(sd1),
        .o_frame_start(fs1), .o_drop(dr1)
    );

    int n_chk = 0;
    int n_pass = 0;

    // model state per instance: edges since release, last valid, frame, drops
    int          mn [2];
    int          mle [2];
    logic [15:0] mlv [2];
    logic [15:0] mf [2];
    int          md [2];
    logic [31:0] rx [2][32];

    function automatic int dv(input int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic bit is_snap(input int d, input int n);
        return (n >= 2*d) && (((n - 2*d) % (64*d)) == 0);
    endfunction

    function automatic int s_last(input int d, input int e);
        if (e <= 2*d) return 0;
        return 2*d + 64*d*((e - 1 - 2*d) / (64*d));
    endfunction

    function automatic int next_snap(input int d, input int n);
        if (n < 2*d) return 2*d;
        return 2*d + 64*d*((n - 2*d) / (64*d) + 1);
    endfunction

    function automatic logic [3:0] exp_pins(input int d, input int n,
                                            input logic [15:0] f);
        int k, j;
        logic b, lr, sd, fs;
        logic [3:0] bi;
        b = ((n / d) % 2) == 1;
        if (n < 2*d) return {b, 3'b000};
        k  = (n - 2*d) / (2*d);
        j  = k % 32;
        bi = 4'(15 - (j % 16));
        sd = f[bi];
        lr = ((j + 1) % 32) >= 16;
        fs = ((n - 2*d) % (64*d)) == 0;
        return {b, lr, sd, fs};
    endfunction

    function automatic logic [3:0] pins(input int id);
        return (id == 0) ? {b4, lr4, sd4, fs4} : {b1, lr1, sd1, fs1};
    endfunction

    task automatic reset_model(input int id);
        mn[id] = 0; mle[id] = -1; mlv[id] = 16'd0;
        mf[id] = 16'd0; md[id] = 0;
    endtask

    task automatic tick(input int id, input logic v, input logic [15:0] s);
        int d, k;
        d = dv(id);
        @(negedge clk);
        if (id == 0) begin vld = v; smp = s; end
        else begin vld1 = v; smp1 = s; end
        @(posedge clk);
        #1;
        mn[id]++;
        if (is_snap(d, mn[id])) mf[id] = mlv[id];
        if (v) begin
            if (mle[id] >= s_last(d, mn[id]) && !is_snap(d, mn[id]) && md[id] < 255)
                md[id]++;
            mle[id] = mn[id];
            mlv[id] = s;
        end
        if (mn[id] >= 3*d && ((mn[id] - 3*d) % (2*d)) == 0) begin
            k = (mn[id] - 3*d) / (2*d);
            if (k / 32 < 32) rx[id][k/32][31 - (k % 32)] = (id == 0) ? sd4 : sd1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n1 = 1'b0;
        vld = 1'b0; vld1 = 1'b0; smp = 16'd0; smp1 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({pins(0), dr4, pins(1), dr1} !== 24'd0)
            $display("FAIL reset got %b exp 0", {pins(0), dr4, pins(1), dr1});
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        reset_model(0);
    endtask

    task automatic test_first_frame();
        logic [3:0] e;
        while (mn[0] < 2*4 + 64*4 + 8) begin
            tick(0, mn[0] == 0, 16'h8001);
            e = exp_pins(4, mn[0], mf[0]);
            n_chk++;
            if (pins(0) !== e) $display("FAIL ff_pins n=%0d got %b exp %b", mn[0], pins(0), e);
            else n_pass++;
            n_chk++;
            if (dr4 !== 8'(md[0])) $display("FAIL ff_drop got %0d exp %0d", dr4, md[0]);
            else n_pass++;
        end
        n_chk++;
        if (rx[0][0] !== 32'h80018001) $display("FAIL ff_bits got %h exp 80018001", rx[0][0]);
        else n_pass++;
    endtask

    task automatic test_two_valids();
        logic [3:0] e;
        int s0, ed, f;
        s0 = next_snap(4, mn[0]);
        while (mn[0] < s0 + 512 + 8) begin
            ed = mn[0] + 1;
            tick(0, (ed == s0 + 30) || (ed == s0 + 130),
                 (ed == s0 + 30) ? 16'h1234 : 16'h5678);
            e = exp_pins(4, mn[0], mf[0]);
            n_chk++;
            if (pins(0) !== e) $display("FAIL tv_pins n=%0d got %b exp %b", mn[0], pins(0), e);
            else n_pass++;
            n_chk++;
            if (dr4 !== 8'(md[0])) $display("FAIL tv_drop got %0d exp %0d", dr4, md[0]);
            else n_pass++;
        end
        f = (s0 + 256 - 8) / 256;
        n_chk++;
        if (rx[0][f] !== 32'h56785678) $display("FAIL tv_bits got %h exp 56785678", rx[0][f]);
        else n_pass++;
        n_chk++;
        if (dr4 !== 8'd1) $display("FAIL tv_drop1 got %0d exp 1", dr4);
        else n_pass++;
    endtask

    task automatic test_snap_collision();
        logic [3:0] e;
        int s0, ed, f;
        s0 = next_snap(4, mn[0]);
        while (mn[0] < s0 + 768 + 8) begin
            ed = mn[0] + 1;
            tick(0, (ed == s0 + 20) || (ed == s0 + 256),
                 (ed == s0 + 20) ? 16'h1111 : 16'hABCD);
            e = exp_pins(4, mn[0], mf[0]);
            n_chk++;
            if (pins(0) !== e) $display("FAIL sc_pins n=%0d got %b exp %b", mn[0], pins(0), e);
            else n_pass++;
        end
        f = (s0 + 256 - 8) / 256;
        n_chk++;
        if (rx[0][f] !== 32'h11111111) $display("FAIL sc_old got %h exp 11111111", rx[0][f]);
        else n_pass++;
        n_chk++;
        if (rx[0][f+1] !== 32'hABCDABCD) $display("FAIL sc_new got %h exp abcdabcd", rx[0][f+1]);
        else n_pass++;
        n_chk++;
        if (dr4 !== 8'd1) $display("FAIL sc_drop got %0d exp 1", dr4);
        else n_pass++;
    endtask

    task automatic test_underrun();
        logic [3:0] e;
        int s0, f, nfs;
        s0 = next_snap(4, mn[0]);
        nfs = 0;
        while (mn[0] < s0 + 1024 + 8) begin
            tick(0, mn[0] + 1 == s0 + 10, 16'h00F0);
            if (mn[0] >= s0 + 256 && mn[0] < s0 + 1024 && fs4 === 1'b1) nfs++;
            e = exp_pins(4, mn[0], mf[0]);
            n_chk++;
            if (pins(0) !== e) $display("FAIL ur_pins n=%0d got %b exp %b", mn[0], pins(0), e);
            else n_pass++;
        end
        n_chk++;
        if (nfs !== 3) $display("FAIL ur_pulses got %0d exp 3", nfs);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            f = (s0 + 256*i - 8) / 256;
            n_chk++;
            if (rx[0][f] !== 32'h00F000F0) $display("FAIL ur_bits%0d got %h exp 00f000f0", i, rx[0][f]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3:0] e;
        int s0;
        s0 = next_snap(4, mn[0]);
        while (mn[0] < s0 + 5*256 + 8) begin
            tick(0, $urandom_range(0, 19) == 0, 16'($urandom));
            e = exp_pins(4, mn[0], mf[0]);
            n_chk++;
            if (pins(0) !== e) $display("FAIL rnd_pins n=%0d got %b exp %b", mn[0], pins(0), e);
            else n_pass++;
            n_chk++;
            if (dr4 !== 8'(md[0])) $display("FAIL rnd_drop got %0d exp %0d", dr4, md[0]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        int s0, ed;
        s0 = next_snap(4, mn[0]);
        while (mn[0] < s0 + 520) begin
            ed = mn[0] + 1;
            tick(0, ed >= s0 + 1 && ed <= s0 + 300, 16'($urandom));
            e = exp_pins(4, mn[0], mf[0]);
            n_chk++;
            if (pins(0) !== e) $display("FAIL b2b_pins n=%0d got %b exp %b", mn[0], pins(0), e);
            else n_pass++;
            n_chk++;
            if (dr4 !== 8'(md[0])) $display("FAIL b2b_drop got %0d exp %0d", dr4, md[0]);
            else n_pass++;
        end
        n_chk++;
        if (dr4 !== 8'hff) $display("FAIL b2b_sat got %0d exp 255", dr4);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        int s0;
        s0 = next_snap(4, mn[0]);
        while (mn[0] < s0 + 8*20 + 3) tick(0, 1'b0, 16'd0);
        n_chk++;
        if (lr4 !== 1'b1) $display("FAIL rm_inright got %b exp 1", lr4);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({pins(0), dr4} !== 12'd0) $display("FAIL rm_async got %b exp 0", {pins(0), dr4});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        reset_model(0);
        while (mn[0] < 12) begin
            tick(0, 1'b0, 16'd0);
            e = exp_pins(4, mn[0], mf[0]);
            n_chk++;
            if (pins(0) !== e) $display("FAIL rm_pins n=%0d got %b exp %b", mn[0], pins(0), e);
            else n_pass++;
            if (mn[0] == 8) begin
                n_chk++;
                if ({b4, fs4} !== 2'b01) $display("FAIL rm_fall8 got %b exp 01", {b4, fs4});
                else n_pass++;
            end
        end
    endtask

    task automatic test_div1();
        logic [3:0] e;
        rst_n1 = 1'b1;
        reset_model(1);
        while (mn[1] < 2 + 64 + 4) begin
            tick(1, mn[1] == 0, 16'h8001);
            e = exp_pins(1, mn[1], mf[1]);
            n_chk++;
            if (pins(1) !== e) $display("FAIL d1_pins n=%0d got %b exp %b", mn[1], pins(1), e);
            else n_pass++;
            n_chk++;
            if (dr1 !== 8'(md[1])) $display("FAIL d1_drop got %0d exp %0d", dr1, md[1]);
            else n_pass++;
        end
        n_chk++;
        if (rx[1][0] !== 32'h80018001) $display("FAIL d1_bits got %h exp 80018001", rx[1][0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_two_valids();
        test_snap_collision();
        test_underrun();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_div1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
